// File: rtl/unpack_pkg.sv
// Shared helpers for the pack/unpack width converters: lane selection and count width.
package unpack_pkg;

  localparam int MAX_BITS = 1024;

  function automatic int cw(input int d);
    return $clog2(d + 1);
  endfunction

  // Returns the selected lane in the low w bits; the caller truncates.
  function automatic logic [MAX_BITS-1:0] lane_sel(
    input logic [MAX_BITS-1:0] word,
    input int                  k,
    input int                  w,
    input int                  d,
    input bit                  msb_first
  );
    int pos;
    pos = msb_first ? (d - 1 - k) : k;
    return word >> (pos * w);
  endfunction

endpackage

// File: rtl/unpack_stream.sv
// Width down-converter: one W*D-bit word in, up to D W-bit beats out, zero-bubble.
// Registered outputs; lane 0 of a word is presented the cycle after its input handshake.
module unpack_stream
  import unpack_pkg::*;
#(
  parameter int W         = 8,
  parameter int D         = 4,
  parameter int MSB_FIRST = 0,
  localparam int CW       = cw(D)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_stb,
  input  logic [W*D-1:0]  s_dat,
  input  logic [CW-1:0]   s_cnt,
  input  logic            s_lst,
  output logic            s_rdy,
  output logic            m_stb,
  output logic [W-1:0]    m_dat,
  output logic            m_lst,
  input  logic            m_rdy
);

  logic [W*D-1:0] wrd;
  logic [CW-1:0]  idx;
  logic [CW-1:0]  cnt;
  logic           lst;

  logic [CW-1:0]  cnt_in;
  logic [CW-1:0]  idx_nxt;
  logic           fin;

  function automatic logic [W-1:0] lane(input logic [W*D-1:0] v, input logic [CW-1:0] k);
    logic [MAX_BITS-1:0] wide;
    logic [MAX_BITS-1:0] sel;
    wide            = '0;
    wide[W*D-1:0]   = v;
    sel             = lane_sel(wide, int'(k), W, D, MSB_FIRST != 0);
    return sel[W-1:0];
  endfunction

  always_comb begin
    cnt_in  = (s_cnt > CW'(D)) ? CW'(D) : s_cnt;
    idx_nxt = idx + CW'(1);
    fin     = m_stb && (idx == cnt - CW'(1));
    s_rdy   = !rst && (!m_stb || (fin && m_rdy));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrd   <= '0;
      idx   <= '0;
      cnt   <= '0;
      lst   <= 1'b0;
      m_stb <= 1'b0;
      m_dat <= '0;
      m_lst <= 1'b0;
    end else if (s_stb && s_rdy) begin
      // Load wins over finish so the next word's lane 0 follows the last beat directly.
      if (cnt_in != '0) begin
        wrd   <= s_dat;
        cnt   <= cnt_in;
        lst   <= s_lst;
        idx   <= '0;
        m_stb <= 1'b1;
        m_dat <= lane(s_dat, '0);
        m_lst <= s_lst && (cnt_in == CW'(1));
      end else begin
        m_stb <= 1'b0;
      end
    end else if (m_stb && m_rdy) begin
      if (fin) begin
        m_stb <= 1'b0;
      end else begin
        idx   <= idx_nxt;
        m_dat <= lane(wrd, idx_nxt);
        m_lst <= lst && (idx_nxt == cnt - CW'(1));
      end
    end
  end

endmodule

// File: tb/tb_unpack_stream.sv
// Directed bench for unpack_stream (W=8, D=4): queue scoreboard plus per-cycle spot checks.
module tb_unpack_stream;

  typedef struct packed {
    logic [7:0] dat;
    logic       lst;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        s_stb = 1'b0;
  logic [31:0] s_dat = '0;
  logic [2:0]  s_cnt = '0;
  logic        s_lst = 1'b0;
  logic        s_rdy;
  logic        m_stb;
  logic [7:0]  m_dat;
  logic        m_lst;
  logic        m_rdy = 1'b1;

  logic        s1_stb = 1'b0;
  logic [31:0] s1_dat = '0;
  logic [2:0]  s1_cnt = '0;
  logic        s1_lst = 1'b0;
  logic        s1_rdy;
  logic        m1_stb;
  logic [7:0]  m1_dat;
  logic        m1_lst;
  logic        m1_rdy = 1'b1;

  int    vecs = 0;
  int    errs = 0;
  int    cyc  = 0;
  int    acc_cyc = 0;
  beat_t q0[$];
  beat_t q1[$];
  int    beat_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  unpack_stream #(.W(8), .D(4), .MSB_FIRST(0)) dut0 (
    .clk(clk), .rst(rst),
    .s_stb(s_stb), .s_dat(s_dat), .s_cnt(s_cnt), .s_lst(s_lst), .s_rdy(s_rdy),
    .m_stb(m_stb), .m_dat(m_dat), .m_lst(m_lst), .m_rdy(m_rdy)
  );

  unpack_stream #(.W(8), .D(4), .MSB_FIRST(1)) dut1 (
    .clk(clk), .rst(rst),
    .s_stb(s1_stb), .s_dat(s1_dat), .s_cnt(s1_cnt), .s_lst(s1_lst), .s_rdy(s1_rdy),
    .m_stb(m1_stb), .m_dat(m1_dat), .m_lst(m1_lst), .m_rdy(m1_rdy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && m_stb && m_rdy) begin
      beat_t e;
      vecs++;
      beat_cyc.push_back(cyc);
      if (q0.size() == 0) begin
        errs++;
        $display("FAIL beat0: got dat=%h lst=%b, expected no beat", m_dat, m_lst);
      end else begin
        e = q0.pop_front();
        if (m_dat !== e.dat || m_lst !== e.lst) begin
          errs++;
          $display("FAIL beat0: got dat=%h lst=%b, expected dat=%h lst=%b", m_dat, m_lst, e.dat, e.lst);
        end
      end
    end
    if (!rst && m1_stb && m1_rdy) begin
      beat_t e;
      vecs++;
      if (q1.size() == 0) begin
        errs++;
        $display("FAIL beat1: got dat=%h lst=%b, expected no beat", m1_dat, m1_lst);
      end else begin
        e = q1.pop_front();
        if (m1_dat !== e.dat || m1_lst !== e.lst) begin
          errs++;
          $display("FAIL beat1: got dat=%h lst=%b, expected dat=%h lst=%b", m1_dat, m1_lst, e.dat, e.lst);
        end
      end
    end
  end

  task automatic exp0(input logic [7:0] d, input logic l);
    beat_t b;
    b.dat = d;
    b.lst = l;
    q0.push_back(b);
  endtask

  task automatic exp1(input logic [7:0] d, input logic l);
    beat_t b;
    b.dat = d;
    b.lst = l;
    q1.push_back(b);
  endtask

  // Presents a word and returns at posedge+1 of the accepting edge.
  task automatic send0(input logic [31:0] d, input logic [2:0] c, input logic l);
    bit ok;
    int n;
    ok = 1'b0;
    n  = 0;
    s_stb = 1'b1; s_dat = d; s_cnt = c; s_lst = l;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = s_rdy;
      @(posedge clk);
      #1;
      n++;
    end
    s_stb = 1'b0;
    acc_cyc = cyc;
    if (!ok) begin
      vecs++;
      errs++;
      $display("FAIL send0_timeout: got no s_rdy in %0d cycles, expected handshake", n);
    end
  endtask

  task automatic drain0;
    int n;
    n = 0;
    while ((q0.size() != 0 || m_stb) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain0_empty", q0.size(), 0);
  endtask

  initial begin
    // Reset held 3 cycles with s_stb asserted.
    s_stb = 1'b1; s_dat = 32'h44332211; s_cnt = 3'd4;
    repeat (3) begin
      @(negedge clk);
      check("rst_s_rdy", s_rdy, 0);
      check("rst_m_stb", m_stb, 0);
      check("rst_m_dat", m_dat, 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    s_stb = 1'b0;
    @(negedge clk);
    check("post_rst_s_rdy", s_rdy, 1);
    @(posedge clk);
    #1;

    // Back-to-back words, no bubble.
    beat_cyc.delete();
    m_rdy = 1'b1;
    send0(32'h44332211, 3'd4, 1'b0);
    exp0(8'h11, 0); exp0(8'h22, 0); exp0(8'h33, 0); exp0(8'h44, 0);
    send0(32'h88776655, 3'd4, 1'b1);
    exp0(8'h55, 0); exp0(8'h66, 0); exp0(8'h77, 0); exp0(8'h88, 1);
    check("b2b_accept_on_beat44", acc_cyc, beat_cyc[3] + 1);
    drain0();
    check("b2b_beats", beat_cyc.size(), 8);
    check("b2b_contiguous", beat_cyc[7] - beat_cyc[0], 7);

    // MSB-first instance.
    begin
      bit ok;
      int n;
      ok = 1'b0;
      n  = 0;
      s1_stb = 1'b1; s1_dat = 32'h44332211; s1_cnt = 3'd4; s1_lst = 1'b1;
      while (!ok && n < 50) begin
        @(negedge clk);
        ok = s1_rdy;
        @(posedge clk);
        #1;
        n++;
      end
      s1_stb = 1'b0;
      check("msb_accept", ok, 1);
      exp1(8'h44, 0); exp1(8'h33, 0); exp1(8'h22, 0); exp1(8'h11, 1);
      repeat (8) @(posedge clk);
      #1;
      check("msb_drained", q1.size(), 0);
      check("msb_idle", m1_stb, 0);
    end

    // Partial last word.
    send0(32'hDDCCBBAA, 3'd2, 1'b1);
    exp0(8'hAA, 0); exp0(8'hBB, 1);
    drain0();
    @(negedge clk);
    check("partial_idle", m_stb, 0);
    @(posedge clk);
    #1;

    // Backpressure while beat 22 is presented.
    m_rdy = 1'b0;
    send0(32'h44332211, 3'd4, 1'b0);
    exp0(8'h11, 0); exp0(8'h22, 0); exp0(8'h33, 0); exp0(8'h44, 0);
    m_rdy = 1'b1;
    @(posedge clk);
    #1;
    m_rdy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("bp_m_dat", m_dat, 32'h22);
      check("bp_m_stb", m_stb, 1);
      check("bp_s_rdy", s_rdy, 0);
      @(posedge clk);
      #1;
    end
    m_rdy = 1'b1;
    drain0();

    // Count above D is clamped to D.
    send0(32'hA4A3A2A1, 3'd7, 1'b1);
    exp0(8'hA1, 0); exp0(8'hA2, 0); exp0(8'hA3, 0); exp0(8'hA4, 1);
    drain0();

    // Zero-count word is consumed without a beat.
    send0(32'h12345678, 3'd0, 1'b1);
    @(negedge clk);
    check("zero_no_beat", m_stb, 0);
    @(posedge clk);
    #1;

    // Reset after beat 11 flushes the rest of the word.
    send0(32'h44332211, 3'd4, 1'b0);
    exp0(8'h11, 0); exp0(8'h22, 0); exp0(8'h33, 0); exp0(8'h44, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    q0.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("flush_m_stb", m_stb, 0);
    check("flush_s_rdy", s_rdy, 1);
    repeat (6) @(posedge clk);
    #1;
    check("flush_no_beats", m_stb, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
